// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
// ---------------------------------------------------------------------------
// Pipelined AES/Rijndael ShiftRows, forward or inverse per block, for
// Nb = 4, 6 or 8 columns. The byte permutation is combinational in front of
// stage 0. Stages 1..STAGES-1 only delay the block. A valid/ready handshake
// with bubble collapsing gives full backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input block valid
//   in_ready   unit accepts a block this cycle
//   in_data    input state, byte k at [DW-1-8k -: 8], k = row + 4*col
//   in_inv     0 = forward ShiftRows, 1 = inverse ShiftRows
//   in_tag     sideband tag, passed through unchanged
//   out_valid  output block valid
//   out_ready  downstream accepts this cycle
//   out_data   permuted state
//   out_inv    mode the output block was processed with
//   out_tag    tag of the output block
//   occupancy  number of valid stages, 0..STAGES
// ---------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*NB-1:0]     in_data,
    input  logic                 in_inv,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*NB-1:0]     out_data,
    output logic                 out_inv,
    output logic [TAG_W-1:0]     out_tag,
    output logic [2:0]           occupancy
);

    localparam int DW = 32 * NB;

    if ((NB != 32'sd4) && (NB != 32'sd6) && (NB != 32'sd8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if ((STAGES < 32'sd1) || (STAGES > 32'sd4)) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be in 1..4");
    end
    if (TAG_W < 32'sd1) begin : g_bad_tag
        $error("shift_rows_pipe: TAG_W must be at least 1");
    end

    // Row rotation amount; Nb = 8 uses the wider offsets for rows 2 and 3.
    function automatic int row_shift(input int r);
        int s;
        case (r)
            0:       s = 0;
            1:       s = 1;
            2:       s = (NB == 32'sd8) ? 3 : 2;
            default: s = (NB == 32'sd8) ? 4 : 3;
        endcase
        return s;
    endfunction

    // Rotate each row left (forward) or right (inverse) by its offset.
    function automatic logic [DW-1:0] permute(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] res;
        int            src;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) begin
                    src = (c + NB - row_shift(r)) % NB;
                end else begin
                    src = (c + row_shift(r)) % NB;
                end
                res[DW-1-8*(r+4*c) -: 8] = d[DW-1-8*(r+4*src) -: 8];
            end
        end
        return res;
    endfunction

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] inv_r;
    logic [DW-1:0]     data_r [STAGES];
    logic [TAG_W-1:0]  tag_r  [STAGES];

    logic [STAGES-1:0] adv_s;
    logic [DW-1:0]     perm_s;
    logic [2:0]        occ_s;

    // Advance chain: a stage moves when it is empty or its successor moves;
    // evaluated from the output end so out_ready ripples back to stage 0.
    always_comb begin
        logic succ_v;
        succ_v = out_ready;
        adv_s  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv_s[i] = !valid_r[i] || succ_v;
            succ_v   = adv_s[i];
        end
    end

    // Combinational byte permutation of the incoming block.
    always_comb begin
        perm_s = permute(in_data, in_inv);
    end

    // Stage registers: stage 0 takes the permuted input, later stages take
    // their predecessor; a stalled stage holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            inv_r   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_r[i] <= '0;
                tag_r[i]  <= '0;
            end
        end else begin
            if (adv_s[0]) begin
                valid_r[0] <= in_valid;
                data_r[0]  <= perm_s;
                inv_r[0]   <= in_inv;
                tag_r[0]   <= in_tag;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv_s[i]) begin
                    valid_r[i] <= valid_r[i-1];
                    data_r[i]  <= data_r[i-1];
                    inv_r[i]   <= inv_r[i-1];
                    tag_r[i]   <= tag_r[i-1];
                end
            end
        end
    end

    // Population count of the stage valids.
    always_comb begin
        occ_s = 3'd0;
        for (int i = 0; i < STAGES; i++) begin
            occ_s = occ_s + {2'b00, valid_r[i]};
        end
    end

    // Reset masks both handshakes so nothing transfers during the reset cycle.
    assign in_ready  = adv_s[0] && !rst;
    assign out_valid = valid_r[STAGES-1] && !rst;
    assign out_data  = data_r[STAGES-1];
    assign out_inv   = inv_r[STAGES-1];
    assign out_tag   = tag_r[STAGES-1];
    assign occupancy = occ_s;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4/STAGES=3, NB=8/STAGES=2 and
// NB=6/STAGES=1 instances share one clock and reset.
module tb_shift_rows_pipe;

    logic clk;
    logic rst;

    // NB=4, STAGES=3
    logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, out_inv4;
    logic [127:0] in_data4, out_data4;
    logic [3:0]   in_tag4, out_tag4;
    logic [2:0]   occ4;
    // NB=8, STAGES=2
    logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
    logic [255:0] in_data8, out_data8;
    logic [3:0]   in_tag8, out_tag8;
    logic [2:0]   occ8;
    // NB=6, STAGES=1
    logic         in_valid6, in_ready6, in_inv6, out_valid6, out_ready6, out_inv6;
    logic [191:0] in_data6, out_data6;
    logic [3:0]   in_tag6, out_tag6;
    logic [2:0]   occ6;

    int vectors;
    int miscompares;

    // Hand-written AES source-byte tables for Nb=4 (output byte k <- input byte).
    localparam int FWD4 [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    localparam int INV4 [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    localparam logic [127:0] V4     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V4_FWD = 128'h0055aaff4499ee3388dd2277cc1166bb;
    localparam logic [127:0] V4_INV = 128'h00ddaa774411eebb885522ffcc996633;

    localparam logic [255:0] SEQ8 = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [255:0] FWD8 = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
    localparam logic [255:0] INV8 = 256'h001d1613_04011a17_08051e1b_0c09021f_100d0603_14110a07_18150e0b_1c19120f;

    localparam logic [191:0] SEQ6 = 192'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617;
    localparam logic [191:0] FWD6 = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;
    localparam logic [191:0] INV6 = 192'h0015120f_04011613_08050217_0c090603_100d0a07_14110e0b;

    logic [127:0] blk  [8];
    logic [127:0] fexp [8];
    logic [127:0] bp   [4];

    shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .in_inv(in_inv4), .in_tag(in_tag4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_inv(out_inv4), .out_tag(out_tag4), .occupancy(occ4)
    );

    shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_inv(in_inv8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_inv(out_inv8), .out_tag(out_tag8), .occupancy(occ8)
    );

    shift_rows_pipe #(.NB(6), .STAGES(1), .TAG_W(4)) u_dut6 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
        .in_inv(in_inv6), .in_tag(in_tag6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .out_inv(out_inv6), .out_tag(out_tag6), .occupancy(occ6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table-driven Nb=4 reference model.
    function automatic logic [127:0] model4(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        int           s;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            s = inv ? INV4[k] : FWD4[k];
            r[127-8*k -: 8] = d[127-8*s -: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One block through the 3-stage Nb=4 unit; result due three cycles later.
    task automatic run4(input logic [127:0] d, input logic inv, input logic [3:0] tag,
                        input logic [127:0] exp);
        @(negedge clk);
        in_valid4 = 1'b1; in_data4 = d; in_inv4 = inv; in_tag4 = tag;
        @(negedge clk);
        in_valid4 = 1'b0;
        chk("nb4_lat1_valid", {255'd0, out_valid4}, 256'd0);
        @(negedge clk);
        chk("nb4_lat2_valid", {255'd0, out_valid4}, 256'd0);
        @(negedge clk);
        chk("nb4_valid", {255'd0, out_valid4}, 256'd1);
        chk("nb4_data", {128'd0, out_data4}, {128'd0, exp});
        chk("nb4_inv", {255'd0, out_inv4}, {255'd0, inv});
        chk("nb4_tag", {252'd0, out_tag4}, {252'd0, tag});
    endtask

    task automatic run8(input logic [255:0] d, input logic inv, input logic [3:0] tag,
                        input logic [255:0] exp);
        @(negedge clk);
        in_valid8 = 1'b1; in_data8 = d; in_inv8 = inv; in_tag8 = tag;
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("nb8_lat1_valid", {255'd0, out_valid8}, 256'd0);
        @(negedge clk);
        chk("nb8_valid", {255'd0, out_valid8}, 256'd1);
        chk("nb8_data", out_data8, exp);
        chk("nb8_inv", {255'd0, out_inv8}, {255'd0, inv});
        chk("nb8_tag", {252'd0, out_tag8}, {252'd0, tag});
    endtask

    task automatic run6(input logic [191:0] d, input logic inv, input logic [3:0] tag,
                        input logic [191:0] exp);
        @(negedge clk);
        in_valid6 = 1'b1; in_data6 = d; in_inv6 = inv; in_tag6 = tag;
        @(negedge clk);
        in_valid6 = 1'b0;
        chk("nb6_valid", {255'd0, out_valid6}, 256'd1);
        chk("nb6_data", {64'd0, out_data6}, {64'd0, exp});
        chk("nb6_inv", {255'd0, out_inv6}, {255'd0, inv});
        chk("nb6_tag", {252'd0, out_tag6}, {252'd0, tag});
    endtask

    // Eight back-to-back blocks, mode alternating from inv0; checks order,
    // latency and one-per-cycle delivery.
    task automatic stream4(input logic [127:0] din [8], input logic [127:0] dexp [8],
                           input logic inv0);
        int got;
        int first;
        int last;
        got   = 0;
        first = -1;
        last  = -1;
        out_ready4 = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (out_valid4) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (got < 8) begin
                    chk("stream_data", {128'd0, out_data4}, {128'd0, dexp[got]});
                    chk("stream_inv", {255'd0, out_inv4}, {255'd0, inv0 ^ got[0]});
                    chk("stream_tag", {252'd0, out_tag4}, {252'd0, got[3:0]});
                end
                got++;
            end
            if (cyc < 8) begin
                in_valid4 = 1'b1;
                in_data4  = din[cyc];
                in_inv4   = inv0 ^ cyc[0];
                in_tag4   = cyc[3:0];
                #1;
                chk("stream_in_ready", {255'd0, in_ready4}, 256'd1);
            end else begin
                in_valid4 = 1'b0;
            end
        end
        chk("stream_first_cycle", first, 256'd3);
        chk("stream_last_cycle", last, 256'd10);
        chk("stream_count", got, 256'd8);
    endtask

    initial begin
        int sent;
        int rcv;
        int seen;

        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; in_inv4 = 1'b0; in_tag4 = '0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_inv8 = 1'b0; in_tag8 = '0; out_ready8 = 1'b1;
        in_valid6 = 1'b0; in_data6 = '0; in_inv6 = 1'b0; in_tag6 = '0; out_ready6 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid4", {255'd0, out_valid4}, 256'd0);
        chk("rst_occ4", {253'd0, occ4}, 256'd0);
        chk("rst_in_ready4", {255'd0, in_ready4}, 256'd1);
        chk("rst_out_data4", {128'd0, out_data4}, 256'd0);
        chk("rst_out_valid8", {255'd0, out_valid8}, 256'd0);
        chk("rst_occ8", {253'd0, occ8}, 256'd0);
        chk("rst_in_ready8", {255'd0, in_ready8}, 256'd1);
        chk("rst_out_valid6", {255'd0, out_valid6}, 256'd0);
        chk("rst_occ6", {253'd0, occ6}, 256'd0);
        chk("rst_in_ready6", {255'd0, in_ready6}, 256'd1);

        // Nb=4 known vectors, both modes
        run4(V4, 1'b0, 4'd5, V4_FWD);
        run4(V4, 1'b1, 4'd9, V4_INV);
        run4(V4_FWD, 1'b1, 4'd2, V4);

        // Nb=8 and Nb=6: both modes plus round trips
        run8(SEQ8, 1'b0, 4'd3, FWD8);
        run8(SEQ8, 1'b1, 4'd4, INV8);
        run8(FWD8, 1'b1, 4'd6, SEQ8);
        run8(INV8, 1'b0, 4'd7, SEQ8);
        run6(SEQ6, 1'b0, 4'd1, FWD6);
        run6(SEQ6, 1'b1, 4'd2, INV6);
        run6(FWD6, 1'b1, 4'd11, SEQ6);
        run6(INV6, 1'b0, 4'd12, SEQ6);

        // Back-to-back stream with alternating mode, then opposite-mode return
        for (int i = 0; i < 8; i++) begin
            blk[i]  = {$urandom, $urandom, $urandom, $urandom};
            fexp[i] = model4(blk[i], i[0]);
        end
        stream4(blk, fexp, 1'b0);
        stream4(fexp, blk, 1'b1);

        // Backpressure: out_ready low for five cycles while streaming
        for (int i = 0; i < 4; i++) bp[i] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0;
        out_ready4 = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (cyc >= 3) begin
                chk("bp_out_valid", {255'd0, out_valid4}, 256'd1);
                chk("bp_out_tag", {252'd0, out_tag4}, 256'd0);
                chk("bp_out_data", {128'd0, out_data4}, {128'd0, model4(bp[0], 1'b0)});
                chk("bp_occ", {253'd0, occ4}, 256'd3);
            end
            in_valid4 = 1'b1;
            in_data4  = bp[sent];
            in_inv4   = sent[0];
            in_tag4   = sent[3:0];
            #1;
            chk("bp_in_ready", {255'd0, in_ready4}, (cyc < 3) ? 256'd1 : 256'd0);
            if (in_ready4) sent++;
        end
        rcv = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            out_ready4 = 1'b1;
            if (out_valid4) begin
                if (rcv < 4) begin
                    chk("bp_rel_tag", {252'd0, out_tag4}, rcv);
                    chk("bp_rel_data", {128'd0, out_data4}, {128'd0, model4(bp[rcv], rcv[0])});
                end
                rcv++;
            end
            if (sent < 4) begin
                in_valid4 = 1'b1;
                in_data4  = bp[sent];
                in_inv4   = sent[0];
                in_tag4   = sent[3:0];
            end else begin
                in_valid4 = 1'b0;
            end
            #1;
            if (in_valid4 && in_ready4) sent++;
        end
        chk("bp_rcv_count", rcv, 256'd4);
        chk("bp_sent_count", sent, 256'd4);
        chk("bp_occ_drained", {253'd0, occ4}, 256'd0);

        // Reset with three blocks in flight; input held valid during reset
        out_ready4 = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            in_valid4 = 1'b1;
            in_data4  = blk[cyc];
            in_inv4   = 1'b1;
            in_tag4   = 4'hf;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid4 = 1'b0;
        #1;
        chk("midrst_out_valid", {255'd0, out_valid4}, 256'd0);
        chk("midrst_occ", {253'd0, occ4}, 256'd0);
        chk("midrst_in_ready", {255'd0, in_ready4}, 256'd1);
        chk("midrst_out_data", {128'd0, out_data4}, 256'd0);
        chk("midrst_out_inv", {255'd0, out_inv4}, 256'd0);
        chk("midrst_out_tag", {252'd0, out_tag4}, 256'd0);
        seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (out_valid4) seen++;
        end
        chk("midrst_no_stale", seen, 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
